video_pattern_gen: RTL and testbench
====================================

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameters SHALL be: H_ACTIVE 1920 active pixels/line; H_FRONT 88; H_SYNC 44; H_BACK 148; V_ACTIVE 1080 active lines/frame; V_FRONT 4; V_SYNC 5; V_BACK 36; SYNC_POL 1 (1 = sync pulses active-high).
REQ-002 iClk  in  1  single clock; all logic on posedge.
REQ-003 iRst  in  1  asynchronous, active-low reset.
REQ-004 iEnable  in  1  start/stop stream generation.
REQ-005 iPattern  in  3  pattern select; latched at frame start.
REQ-006 iColor  in  24  solid colour {R,G,B}; latched at frame start.
REQ-007 oR, oG, oB  out  8 each  pixel data.
REQ-008 oHSync, oVSync  out  1 each  sync pulses, polarity per SYNC_POL.
REQ-009 oDataValid  out  1  high on active pixels.
REQ-010 oLineValid  out  1  high on every cycle of active lines.
REQ-011 oFrameCnt  out  16  count of completed frames, wraps 0xFFFF->0.

Function
REQ-012 Counters SHALL be hcnt 0..H_TOTAL-1 and vcnt 0..V_TOTAL-1, where H_TOTAL and V_TOTAL are the sums of their four parameters.
REQ-013 vcnt SHALL increment when hcnt wraps, and SHALL wrap to 0 at V_TOTAL-1.
REQ-014 Line order SHALL be active, front porch, sync, back porch; frame order SHALL follow the same sequence over lines.
REQ-015 oDataValid SHALL be 1 iff hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-016 oLineValid SHALL be 1 iff vcnt<V_ACTIVE, for the full H_TOTAL cycles of that line.
REQ-017 oHSync SHALL be asserted iff H_ACTIVE+H_FRONT <= hcnt < H_ACTIVE+H_FRONT+H_SYNC, on every line.
REQ-018 oVSync SHALL be asserted for whole lines iff V_ACTIVE+V_FRONT <= vcnt < V_ACTIVE+V_FRONT+V_SYNC.
REQ-019 All outputs SHALL be registered and mutually aligned: each output reflects the (hcnt,vcnt) of the previous cycle, giving one cycle of latency.
REQ-020 FSM states SHALL be IDLE and RUN.
REQ-021 IDLE SHALL hold hcnt=vcnt=0 and drive pixels 0, valids 0 and syncs inactive.
REQ-022 IDLE->RUN SHALL occur on the first cycle iEnable=1; the first active pixel appears on the outputs one cycle later.
REQ-023 RUN->IDLE SHALL occur only at frame end (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1) with iEnable=0; a deassertion of iEnable mid-frame SHALL let the current frame complete.
REQ-024 If iEnable=1 at frame end, the next frame SHALL start with no gap.
REQ-025 oFrameCnt SHALL increment at every frame end in RUN, and SHALL hold in IDLE.
REQ-026 iPattern and iColor SHALL be sampled when hcnt=0, vcnt=0 in RUN; mid-frame changes SHALL be ignored.
REQ-027 Pattern 0 SHALL be 8 colour bars, each H_ACTIVE/8 wide: white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00). H_ACTIVE SHALL be a multiple of 8. The bar index SHALL come from a bar-width counter; no divider.
REQ-028 Pattern 1 SHALL be R=G=B=hcnt[7:0].
REQ-029 Pattern 2 SHALL be R=G=B=vcnt[7:0].
REQ-030 Pattern 3 SHALL be a checkerboard: white when hcnt[4]^vcnt[4], else black.
REQ-031 Pattern 4 SHALL output the latched iColor.
REQ-032 Pattern 5 SHALL be R=oFrameCnt[7:0], G=hcnt[7:0], B=vcnt[7:0].
REQ-033 Patterns 6 and 7 SHALL output black.
REQ-034 Pixel outputs SHALL be 0 whenever oDataValid=0.

Reset
REQ-035 Asserting iRst=0 SHALL asynchronously force: IDLE, hcnt=vcnt=0, oFrameCnt=0, oR/oG/oB=0, oDataValid=oLineValid=0, oHSync=oVSync=!SYNC_POL, latched pattern=0, latched colour=0.
REQ-036 Reset mid-frame SHALL abort the frame immediately.
REQ-037 After deassertion, operation SHALL resume per REQ-022.

Structure
REQ-038 Package video_pkg SHALL hold pattern code constants (PAT_BARS..PAT_FRAME) and default 1080p timing constants.
REQ-039 Sub-module video_timing_counter SHALL own hcnt/vcnt, the region decode and the frame-end strobe; the top level SHALL own the FSM, latching and pattern logic.

Verification (H_ACTIVE=16, H_FRONT=2, H_SYNC=3, H_BACK=3, V_ACTIVE=4, V_FRONT=1, V_SYNC=2, V_BACK=1: 24x8 = 192 cycles/frame)
REQ-040 Timing: iEnable=1, pattern 1 -> per line, DataValid high 16 cycles with oR=0..15; HSync high 3 cycles starting 18 cycles after the first active pixel; LineValid high 96 cycles; VSync high 48 cycles; frame period 192.
REQ-041 Bars: pattern 0 -> each colour held 2 cycles in order; cycles 0-1 = 0xFFFFFF, cycles 14-15 = 0x000000.
REQ-042 Stop: iEnable dropped at cycle 50 of a frame -> the frame completes, oFrameCnt increments by exactly 1, and outputs stay idle afterwards.
REQ-043 Latch: iPattern 4->3 and iColor change mid-frame -> the current frame stays the old solid colour; the next frame shows the checkerboard.
REQ-044 Reset: iRst=0 at cycle 100 -> all outputs reach reset values without a clock edge; after release with iEnable=1, the first pixel appears 1 cycle later and oFrameCnt=0.
REQ-045 Wrap: preload oFrameCnt to 0xFFFF via force, complete 1 frame -> oFrameCnt=0x0000.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants for the video pattern generator: pattern codes, 1080p timing
// defaults and the FSM state type.
package video_pkg;

  localparam logic [2:0] PAT_BARS    = 3'd0;
  localparam logic [2:0] PAT_HRAMP   = 3'd1;
  localparam logic [2:0] PAT_VRAMP   = 3'd2;
  localparam logic [2:0] PAT_CHECKER = 3'd3;
  localparam logic [2:0] PAT_SOLID   = 3'd4;
  localparam logic [2:0] PAT_FRAME   = 3'd5;

  localparam int unsigned DEF_H_ACTIVE = 1920;
  localparam int unsigned DEF_H_FRONT  = 88;
  localparam int unsigned DEF_H_SYNC   = 44;
  localparam int unsigned DEF_H_BACK   = 148;
  localparam int unsigned DEF_V_ACTIVE = 1080;
  localparam int unsigned DEF_V_FRONT  = 4;
  localparam int unsigned DEF_V_SYNC   = 5;
  localparam int unsigned DEF_V_BACK   = 36;
  localparam bit          DEF_SYNC_POL = 1'b1;

  typedef enum logic {IDLE, RUN} state_e;

  // Counters are kept at least 8 bits wide so the ramp patterns can slice [7:0].
  function automatic int unsigned cnt_width(int unsigned total);
    int unsigned w;
    w = $clog2(total);
    return (w > 32'd8) ? w : 32'd8;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters with region decode and frame strobes.
module video_timing_counter
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRun,
  output logic [7:0] oHLo,
  output logic [7:0] oVLo,
  output logic       oHActive,
  output logic       oLineActive,
  output logic       oDataActive,
  output logic       oHSync,
  output logic       oVSync,
  output logic       oLineEnd,
  output logic       oFrameStart,
  output logic       oFrameEnd
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW = cnt_width(H_TOTAL);
  localparam int unsigned VW = cnt_width(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;

  // Counters sit at the origin whenever the generator is not running.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (!iRun) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == H_LAST) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + VW'(1);
    end else begin
      r_hcnt <= r_hcnt + HW'(1);
    end
  end

  assign oHLo        = r_hcnt[7:0];
  assign oVLo        = r_vcnt[7:0];
  assign oHActive    = r_hcnt < H_ACT;
  assign oLineActive = r_vcnt < V_ACT;
  assign oDataActive = oHActive & oLineActive;
  assign oHSync      = (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
  assign oVSync      = (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);
  assign oLineEnd    = r_hcnt == H_LAST;
  assign oFrameStart = (r_hcnt == '0) && (r_vcnt == '0);
  assign oFrameEnd   = (r_hcnt == H_LAST) && (r_vcnt == V_LAST);

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: run/idle control, per-frame pattern latching and
// registered, mutually aligned pixel/sync/valid outputs.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter bit          SYNC_POL = DEF_SYNC_POL
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEnable,
  input  logic [2:0]  iPattern,
  input  logic [23:0] iColor,
  output logic [7:0]  oR,
  output logic [7:0]  oG,
  output logic [7:0]  oB,
  output logic        oHSync,
  output logic        oVSync,
  output logic        oDataValid,
  output logic        oLineValid,
  output logic [15:0] oFrameCnt
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  state_e r_state, w_state_next;
  logic        w_run;
  logic [7:0]  w_hlo, w_vlo;
  logic        w_h_active, w_line_active, w_data_active, w_hsync, w_vsync;
  logic        w_line_end, w_frame_start, w_frame_end;
  logic [2:0]  r_pat, w_pat;
  logic [23:0] r_col, w_col, w_pix;
  logic [BW-1:0] r_bar_cnt;
  logic [2:0]  r_bar_idx;
  logic [7:0]  r_r, r_g, r_b;
  logic        r_hsync, r_vsync, r_dv, r_lv;
  logic [15:0] r_frame_cnt;

  assign w_run = (r_state == RUN);

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_timing (
    .iClk        (iClk),
    .iRst        (iRst),
    .iRun        (w_run),
    .oHLo        (w_hlo),
    .oVLo        (w_vlo),
    .oHActive    (w_h_active),
    .oLineActive (w_line_active),
    .oDataActive (w_data_active),
    .oHSync      (w_hsync),
    .oVSync      (w_vsync),
    .oLineEnd    (w_line_end),
    .oFrameStart (w_frame_start),
    .oFrameEnd   (w_frame_end)
  );

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Stopping is only honoured at the frame boundary so frames are never truncated.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (iEnable) w_state_next = RUN;
      RUN:  if (w_frame_end && !iEnable) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Bar index tracks hcnt/BAR_W with a small width counter instead of a divider.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (!w_run || w_line_end) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (w_h_active) begin
      if (r_bar_cnt == BAR_LAST) begin
        r_bar_cnt <= '0;
        r_bar_idx <= r_bar_idx + 3'd1;
      end else begin
        r_bar_cnt <= r_bar_cnt + BW'(1);
      end
    end
  end

  // The first pixel of a frame uses the inputs being latched on that same edge.
  always_comb begin
    w_pat = w_frame_start ? iPattern : r_pat;
    w_col = w_frame_start ? iColor : r_col;
    w_pix = '0;
    case (w_pat)
      PAT_BARS:    w_pix = {{8{~r_bar_idx[1]}}, {8{~r_bar_idx[2]}}, {8{~r_bar_idx[0]}}};
      PAT_HRAMP:   w_pix = {3{w_hlo}};
      PAT_VRAMP:   w_pix = {3{w_vlo}};
      PAT_CHECKER: w_pix = (w_hlo[4] ^ w_vlo[4]) ? 24'hFF_FFFF : 24'h00_0000;
      PAT_SOLID:   w_pix = w_col;
      PAT_FRAME:   w_pix = {r_frame_cnt[7:0], w_hlo, w_vlo};
      default:     w_pix = '0;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_r         <= '0;
      r_g         <= '0;
      r_b         <= '0;
      r_hsync     <= ~SYNC_POL;
      r_vsync     <= ~SYNC_POL;
      r_dv        <= 1'b0;
      r_lv        <= 1'b0;
      r_frame_cnt <= '0;
      r_pat       <= '0;
      r_col       <= '0;
    end else begin
      r_dv    <= w_run & w_data_active;
      r_lv    <= w_run & w_line_active;
      r_hsync <= (w_run & w_hsync) ? SYNC_POL : ~SYNC_POL;
      r_vsync <= (w_run & w_vsync) ? SYNC_POL : ~SYNC_POL;
      {r_r, r_g, r_b} <= (w_run & w_data_active) ? w_pix : 24'h00_0000;
      if (w_run && w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_run && w_frame_start) begin
        r_pat <= iPattern;
        r_col <= iColor;
      end
    end
  end

  assign oR         = r_r;
  assign oG         = r_g;
  assign oB         = r_b;
  assign oHSync     = r_hsync;
  assign oVSync     = r_vsync;
  assign oDataValid = r_dv;
  assign oLineValid = r_lv;
  assign oFrameCnt  = r_frame_cnt;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a 24x8 raster: frame-level reference model plus
// hand-derived timing, bar, latch, stop, reset and wrap checks.
module tb_video_pattern_gen;

  localparam int unsigned HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = 24, VT = 8, FT = HT * VT;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iEnable;
  logic [2:0]  iPattern;
  logic [23:0] iColor;
  logic [7:0]  oR, oG, oB;
  logic        oHSync, oVSync, oDataValid, oLineValid;
  logic [15:0] oFrameCnt;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        dv;
    logic        lv;
    logic [15:0] fc;
  } out_t;

  typedef struct {
    int         pos;
    logic       dv;
    logic       lv;
    logic       hs;
    logic       vs;
    logic [7:0] r;
  } tvec_t;

  int          n_vec = 0;
  int          n_err = 0;
  bit          m_run;
  int          m_pos;
  logic [15:0] m_fcnt;
  logic [2:0]  m_pat;
  logic [23:0] m_col;
  out_t        last, e_last;
  out_t        cap [200];
  logic [23:0] bar_tab [8];
  tvec_t       tv [16];

  video_pattern_gen #(
    .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .SYNC_POL (1'b1)
  ) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iEnable    (iEnable),
    .iPattern   (iPattern),
    .iColor     (iColor),
    .oR         (oR),
    .oG         (oG),
    .oB         (oB),
    .oHSync     (oHSync),
    .oVSync     (oVSync),
    .oDataValid (oDataValid),
    .oLineValid (oLineValid),
    .oFrameCnt  (oFrameCnt)
  );

  always #5 iClk = ~iClk;

  function automatic out_t sample();
    out_t o;
    o.rgb = {oR, oG, oB};
    o.hs  = oHSync;
    o.vs  = oVSync;
    o.dv  = oDataValid;
    o.lv  = oLineValid;
    o.fc  = oFrameCnt;
    return o;
  endfunction

  function automatic logic [23:0] ref_pix(logic [2:0] pat, logic [23:0] col, int h, int v,
                                          logic [15:0] fc);
    logic [7:0] hb, vb;
    hb = 8'(h);
    vb = 8'(v);
    case (pat)
      3'd0: return bar_tab[h / (HA / 8)];
      3'd1: return {hb, hb, hb};
      3'd2: return {vb, vb, vb};
      3'd3: return ((((h >> 4) ^ (v >> 4)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      3'd4: return col;
      3'd5: return {fc[7:0], hb, vb};
      default: return 24'h000000;
    endcase
  endfunction

  task automatic check_out(string name, out_t act, out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got rgb=%h hs=%b vs=%b dv=%b lv=%b fc=%h, want rgb=%h hs=%b vs=%b dv=%b lv=%b fc=%h",
               name, act.rgb, act.hs, act.vs, act.dv, act.lv, act.fc,
               exp.rgb, exp.hs, exp.vs, exp.dv, exp.lv, exp.fc);
    end
  endtask

  task automatic check_val(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  // Predict the outputs of the coming edge from the frame-position model, then compare.
  task automatic tick(string name);
    out_t        e;
    int          h, v;
    logic [2:0]  pat;
    logic [23:0] col;
    e = '0;
    if (m_run) begin
      h   = m_pos % HT;
      v   = m_pos / HT;
      pat = (m_pos == 0) ? iPattern : m_pat;
      col = (m_pos == 0) ? iColor : m_col;
      e.dv  = (h < HA) && (v < VA);
      e.lv  = (v < VA);
      e.hs  = (h >= HA + HF) && (h < HA + HF + HS);
      e.vs  = (v >= VA + VF) && (v < VA + VF + VS);
      e.rgb = e.dv ? ref_pix(pat, col, h, v, m_fcnt) : 24'h0;
      if (m_pos == 0) begin
        m_pat = pat;
        m_col = col;
      end
      if (m_pos == FT - 1) begin
        m_fcnt = m_fcnt + 16'd1;
        m_pos  = 0;
        if (!iEnable) m_run = 1'b0;
      end else begin
        m_pos++;
      end
    end else if (iEnable) begin
      m_run = 1'b1;
      m_pos = 0;
    end
    e.fc = m_fcnt;
    @(posedge iClk);
    #1;
    last   = sample();
    e_last = e;
    check_out(name, last, e);
  endtask

  task automatic go_frame_start();
    int guard;
    guard = 0;
    while (!(m_run && m_pos == 0)) begin
      tick("run_to_frame_start");
      guard++;
      if (guard > 2 * FT) begin
        n_vec++;
        n_err++;
        $display("FAIL frame_start_timeout: got %0d cycles want <= %0d", guard, 2 * FT);
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_dv, cnt_lv, cnt_hs, cnt_vs, first_hs, guard, cnt;
    logic [15:0] exp_fc;
    out_t idle_o;

    bar_tab = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    // {pos, dv, lv, hs, vs, R} for pattern 1 (horizontal ramp)
    tv = '{'{0, 1, 1, 0, 0, 8'd0},   '{15, 1, 1, 0, 0, 8'd15}, '{16, 0, 1, 0, 0, 8'd0},
           '{17, 0, 1, 0, 0, 8'd0},  '{18, 0, 1, 1, 0, 8'd0},  '{20, 0, 1, 1, 0, 8'd0},
           '{21, 0, 1, 0, 0, 8'd0},  '{23, 0, 1, 0, 0, 8'd0},  '{24, 1, 1, 0, 0, 8'd0},
           '{77, 1, 1, 0, 0, 8'd5},  '{96, 0, 0, 0, 0, 8'd0},  '{120, 0, 0, 0, 1, 8'd0},
           '{138, 0, 0, 1, 1, 8'd0}, '{167, 0, 0, 0, 1, 8'd0}, '{168, 0, 0, 0, 0, 8'd0},
           '{192, 1, 1, 0, 0, 8'd0}};

    m_run = 1'b0; m_pos = 0; m_fcnt = '0; m_pat = '0; m_col = '0;
    iRst = 1'b0; iEnable = 1'b0; iPattern = 3'd1; iColor = 24'h0;
    #1;
    check_out("reset_state", sample(), out_t'(0));
    repeat (3) @(posedge iClk);
    #1 iRst = 1'b1;
    repeat (3) tick("idle_disabled");

    // Line/frame timing with the ramp pattern
    iEnable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick("timing");
      cap[i] = last;
    end
    check_val("first_cycle_latency", int'(cap[0].dv), 0);
    foreach (tv[k]) begin
      check_val($sformatf("timing_pos%0d", tv[k].pos),
                int'({cap[tv[k].pos + 1].dv, cap[tv[k].pos + 1].lv, cap[tv[k].pos + 1].hs,
                      cap[tv[k].pos + 1].vs, cap[tv[k].pos + 1].rgb[23:16]}),
                int'({tv[k].dv, tv[k].lv, tv[k].hs, tv[k].vs, tv[k].r}));
    end
    cnt_dv = 0; cnt_lv = 0; cnt_hs = 0; cnt_vs = 0; first_hs = -1;
    for (int i = 1; i <= FT; i++) begin
      cnt_dv += int'(cap[i].dv);
      cnt_lv += int'(cap[i].lv);
      cnt_hs += int'(cap[i].hs);
      cnt_vs += int'(cap[i].vs);
      if (cap[i].hs && first_hs < 0) first_hs = i - 1;
    end
    check_val("frame_dv_cycles", cnt_dv, 64);
    check_val("frame_lv_cycles", cnt_lv, 96);
    check_val("frame_hs_cycles", cnt_hs, 24);
    check_val("frame_vs_cycles", cnt_vs, 48);
    check_val("first_hsync_offset", first_hs, 18);
    check_val("fcnt_after_frame", int'(cap[FT].fc), 1);

    // Colour bars, two pixels per bar
    iPattern = 3'd0;
    go_frame_start();
    for (int i = 0; i < 16; i++) begin
      tick("bars");
      check_val($sformatf("bar_px%0d", i), int'(last.rgb), int'(bar_tab[i / 2]));
    end

    // Pattern and colour are held for the whole frame
    iPattern = 3'd4; iColor = 24'h123456;
    go_frame_start();
    repeat (10) tick("latch_pre");
    iPattern = 3'd3; iColor = 24'hABCDEF;
    guard = 0;
    while (!(m_run && m_pos == 0) && guard < 2 * FT) begin
      tick("latch_hold");
      guard++;
      if (e_last.dv) check_val("latch_old_colour", int'(last.rgb), 24'h123456);
    end
    tick("latch_next");
    check_val("latch_new_dv", int'(last.dv), 1);
    check_val("latch_new_checker", int'(last.rgb), 0);

    // Randomised run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) iPattern = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) iColor = 24'($urandom);
      iEnable = ($urandom_range(0, 99) < 96);
      tick("random");
    end

    // Stop mid-frame: the frame completes, then idle
    iEnable = 1'b1; iPattern = 3'd5;
    go_frame_start();
    repeat (50) tick("stop_pre");
    iEnable = 1'b0;
    exp_fc = m_fcnt + 16'd1;
    cnt = 0;
    while (m_run && cnt < 2 * FT) begin
      tick("stop_drain");
      cnt++;
    end
    check_val("stop_drain_cycles", cnt, FT - 50);
    check_val("stop_fcnt", int'(last.fc), int'(exp_fc));
    repeat (20) tick("stop_idle");
    idle_o = '0;
    idle_o.fc = exp_fc;
    check_out("stop_idle_outputs", last, idle_o);

    // Asynchronous reset mid-frame
    iEnable = 1'b1; iPattern = 3'd1;
    go_frame_start();
    repeat (100) tick("reset_pre");
    #1 iRst = 1'b0;
    #1;
    check_out("async_reset_no_edge", sample(), out_t'(0));
    m_run = 1'b0; m_pos = 0; m_fcnt = '0; m_pat = '0; m_col = '0;
    #1 iRst = 1'b1;
    tick("reset_resume");
    check_val("reset_first_edge_dv", int'(last.dv), 0);
    tick("reset_first_pixel");
    check_val("reset_first_pixel_dv", int'(last.dv), 1);
    check_val("reset_fcnt", int'(last.fc), 0);

    // Frame counter wrap
    repeat (5) tick("wrap_pre");
    force dut.r_frame_cnt = 16'hFFFF;
    #1 release dut.r_frame_cnt;
    m_fcnt = 16'hFFFF;
    go_frame_start();
    check_val("fcnt_wrap", int'(last.fc), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
